uart_rd_feeder: RTL
===================

// Module: uart_rd_feeder
// PURPOSE
// - Upstream feeder for the Apple-1 video terminal: receives 8N1 serial characters on rxd,
//   buffers them in a small FIFO and presents them on the terminal's rd[7:1]/da/rda handshake.
// - Sits between the board serial pin and the terminal core, in place of the 6821 PIA port B
//   writer. Lets a host PC drive the display for bring-up and demo.
// PARAMETERS
// - CLKS_PER_BIT   124    clk cycles per serial bit (14.31818 MHz / 115200 baud)
// - FIFO_DEPTH_LOG 4      log2 of FIFO depth (default 16 entries)
// - DA_SETUP       2      cycles rd is stable before da rises
// - ACK_TIMEOUT    65535  max cycles da is held waiting for rda low; 0 = wait forever
// PORTS
// - clk          in   1  system clock, same domain as the terminal core
// - rst          in   1  synchronous, active-high reset
// - rxd          in   1  async serial input, idle high
// - rd           out  7  character to terminal, bits [7:1] (ASCII bit 6..0)
// - da           out  1  data available to terminal, active high
// - rda          in   1  terminal ready for data, active high (low while busy)
// - overrun      out  1  sticky: a byte was dropped because the FIFO was full
// - framing_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. Reset values: rd=0, da=0, overrun=0,
//   framing_err=0, FIFO empty, RX FSM and handshake FSM in IDLE.
// - rxd passes a 2-FF synchroniser; FSM sees the synchronised value (2-cycle input latency).
// - RX FSM: IDLE -> START on falling rxd. START samples at CLKS_PER_BIT/2: high = glitch -> IDLE.
//   DATA samples 8 bits LSB-first, one every CLKS_PER_BIT. STOP samples at mid-bit:
//   1 = push byte[6:0]; 0 = framing_err pulse, no push. Then -> IDLE; a new start edge is
//   accepted in the cycle after the stop sample.
// - FIFO: push when not full, or when full and a pop occurs in the same cycle. Push when full
//   with no pop drops the byte and sets overrun until rst. Pop and push on empty: the pushed byte
//   becomes visible next cycle.
// - Handshake FSM:
//   - IDLE: FIFO non-empty and rda=1 -> pop, load rd, go to SETUP.
//   - SETUP: wait DA_SETUP cycles, then da=1, go to HOLD.
//   - HOLD: rda=0 (accepted) -> da=0, go to WAITRDY. Timeout after ACK_TIMEOUT cycles: da=0,
//     char counted delivered, go to WAITRDY.
//   - WAITRDY: rda=1 -> IDLE.
//   - rd is held unchanged from load until the next load.
//   - Minimum spacing between chars is DA_SETUP+3 cycles.
// - rda=0 in IDLE: nothing popped; chars stay buffered.
// - rst mid-frame or mid-handshake: abandons the partial byte and the FIFO contents; da=0 on
//   the cycle after rst is sampled.
// CONFIGURATION
// - LOWERCASE_FOLD_EN defined: bytes 0x61..0x7A are stored as 0x41..0x5A (Apple-1 has no
//   lowercase); all other bytes store bits [6:0].
// - Not defined: bits [6:0] are stored unchanged.
// - Bit 7 of the received byte is always discarded.
// TESTING (bench uses CLKS_PER_BIT=16, DA_SETUP=2, ACK_TIMEOUT=64)
// - Send 0x41, rda=1, terminal model drops rda 3 cycles after da:
//   rd=7'h41, da high >=1 cycle, falls after rda=0.
// - Send 0x0D,0x48,0x49 back-to-back, rda held 0 for 1000 cycles then released:
//   three handshakes in order 0D,48,49, no overrun.
// - Send 17 bytes with rda=0: overrun=1 after 17th stop bit; released FIFO yields first 16 only.
// - Send 0x55 with stop bit forced 0: framing_err pulse, no da activity.
// - 4-cycle low glitch on rxd: no push, no framing_err. Send 0x61: rd=7'h41 with
//   LOWERCASE_FOLD_EN, 7'h61 without.
// - rda never drops after da: da falls after 64 cycles. rst asserted mid-byte: da=0, FIFO empty,
//   next byte 0x5A delivered correctly.

Source files
------------

// File: rtl/uart_rd_feeder.sv
// uart_rd_feeder: 8N1 serial receiver, small character FIFO and the Apple-1
// terminal rd[7:1]/da/rda handshake. A host PC can drive the display through it.
// Optional feature macro: LOWERCASE_FOLD_EN (fold a..z to A..Z before storing).
//
// Handshake (towards the terminal): the feeder pops a character only while rda=1,
// places it on rd, waits DA_SETUP cycles with rd stable, then raises da. The
// terminal acknowledges by pulling rda low, which drops da. The feeder then waits
// for rda to return high before offering the next character. If rda never drops,
// da is released after ACK_TIMEOUT cycles and the character counts as delivered
// (ACK_TIMEOUT=0 waits forever). rd is held from one load until the next load.
module uart_rd_feeder #(
  parameter int CLKS_PER_BIT   = 124,
  parameter int FIFO_DEPTH_LOG = 4,
  parameter int DA_SETUP       = 2,
  parameter int ACK_TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:1] rd,
  output logic       da,
  input  logic       rda,
  output logic       overrun,
  output logic       framing_err
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG;
  localparam int BIT_CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE   = BIT_CW'(1);
  localparam logic [FIFO_DEPTH_LOG:0] FULL_COUNT = (FIFO_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0] CNT_ONE    = (FIFO_DEPTH_LOG + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE  = FIFO_DEPTH_LOG'(1);
  // A setup of 0 still costs the one SETUP cycle.
  localparam logic [15:0] SETUP_LAST = (DA_SETUP > 0) ? 16'(DA_SETUP - 1) : 16'd0;
  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam bit ACK_FOREVER = (ACK_TIMEOUT == 0);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HS_IDLE, HS_SETUP, HS_HOLD, HS_WAITRDY} hs_state_t;

  // ---------------- input synchroniser ----------------
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         rx_state_q, rx_state_d;
  logic [BIT_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [6:0]        rx_data_q, rx_data_d;   // bit 7 of the byte is never kept
  logic              framing_err_q, framing_err_d;
  logic              push;
  logic [6:0]        push_data;

  // Receiver next state: mid-bit sampling, byte assembled LSB first.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_data_d     = rx_data_q;
    framing_err_d = 1'b0;
    push          = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          // Line back high at mid start bit means it was only a glitch.
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BIT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_bit_q != 3'd7) rx_data_d[rx_bit_q] = rxd_s2_q;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + BIT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rxd_s2_q) push          = 1'b1;
          else          framing_err_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + BIT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_data_q     <= 7'd0;
      framing_err_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_data_q     <= rx_data_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Character presented to the FIFO, optionally folded to upper case.
  always_comb begin
`ifdef LOWERCASE_FOLD_EN
    if (rx_data_q >= 7'h61 && rx_data_q <= 7'h7A) push_data = rx_data_q - 7'h20;
    else                                          push_data = rx_data_q;
`else
    push_data = rx_data_q;
`endif
  end

  // ---------------- FIFO ----------------
  logic [6:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
  logic                      overrun_q, overrun_d;
  logic                      fifo_empty, fifo_full, pop, do_push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  // A full FIFO still accepts a byte when a slot frees in the same cycle.
  assign do_push    = push && (!fifo_full || pop);

  // FIFO pointer/count bookkeeping and sticky overrun.
  always_comb begin
    wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !pop) count_d = count_q + CNT_ONE;
    if (!do_push && pop) count_d = count_q - CNT_ONE;
    overrun_d = overrun_q | (push && !do_push);
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // ---------------- terminal handshake ----------------
  hs_state_t   hs_state_q, hs_state_d;
  logic [15:0] hs_cnt_q, hs_cnt_d;
  logic [6:0]  rd_q, rd_d;
  logic        da_q, da_d;

  // Handshake next state: pop, setup delay, hold da until ack or timeout.
  always_comb begin
    hs_state_d = hs_state_q;
    hs_cnt_d   = hs_cnt_q;
    rd_d       = rd_q;
    da_d       = da_q;
    pop        = 1'b0;
    case (hs_state_q)
      HS_IDLE: begin
        if (!fifo_empty && rda) begin
          pop        = 1'b1;
          rd_d       = mem_q[rd_ptr_q];
          hs_cnt_d   = 16'd0;
          hs_state_d = HS_SETUP;
        end
      end
      HS_SETUP: begin
        if (hs_cnt_q == SETUP_LAST) begin
          da_d       = 1'b1;
          hs_cnt_d   = 16'd0;
          hs_state_d = HS_HOLD;
        end else begin
          hs_cnt_d = hs_cnt_q + 16'd1;
        end
      end
      HS_HOLD: begin
        if (!rda) begin
          da_d       = 1'b0;
          hs_state_d = HS_WAITRDY;
        end else if (!ACK_FOREVER && hs_cnt_q == ACK_LAST) begin
          da_d       = 1'b0;
          hs_state_d = HS_WAITRDY;
        end else begin
          hs_cnt_d = hs_cnt_q + 16'd1;
        end
      end
      HS_WAITRDY: begin
        if (rda) hs_state_d = HS_IDLE;
      end
      default: hs_state_d = HS_IDLE;
    endcase
  end

  // Handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state_q <= HS_IDLE;
      hs_cnt_q   <= 16'd0;
      rd_q       <= 7'd0;
      da_q       <= 1'b0;
    end else begin
      hs_state_q <= hs_state_d;
      hs_cnt_q   <= hs_cnt_d;
      rd_q       <= rd_d;
      da_q       <= da_d;
    end
  end

  assign rd          = rd_q;
  assign da          = da_q;
  assign overrun     = overrun_q;
  assign framing_err = framing_err_q;

endmodule
